// File: rtl/gates_pkg.sv
// Shared constants for the tie-cell family (const_low_src, const_high, ...).
//   CONST_LO : logic-0 level driven by tie-low cells
//   CONST_HI : logic-1 level driven by tie-high cells
package gates_pkg;

  localparam logic CONST_LO = 1'b0;
  localparam logic CONST_HI = 1'b1;

endpackage

// File: rtl/tie_reg.sv
// WIDTH-bit register with synchronous active-high reset to RST_VAL.
// Holds the registered copy of a tie cell's constant.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   d   : next value
//   q   : registered value; starts at RST_VAL from time 0
module tie_reg #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // The declaration initialiser makes q valid before the first reset edge.
  logic [WIDTH-1:0] q_r = RST_VAL;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RST_VAL;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/const_low_src.sv
// Tie-low cell: drives a constant all-zeros bus, plus an optional registered
// copy and a sticky integrity flag for the self-test status word.
// Ports:
//   clk : rising-edge clock (used only by the registered copy)
//   rst : synchronous reset, active-high
//   y   : constant all-zeros, purely combinational, independent of clk/rst
//   y_q : registered copy of y (tied to 0 when REG_COPY = 0)
//   err : sticky, set when y_q is ever non-zero outside reset (0 when REG_COPY = 0)
module const_low_src
  import gates_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter bit          REG_COPY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             err
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("const_low_src: WIDTH must be in 1..64");
  end

  assign y = {WIDTH{CONST_LO}};

  if (REG_COPY) begin : g_reg
    logic err_r = CONST_LO;

    tie_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL ({WIDTH{CONST_LO}})
    ) u_tie_reg (
      .clk (clk),
      .rst (rst),
      .d   (y),
      .q   (y_q)
    );

    // Any set bit in the copy means a stuck-at fault or an override upstream.
    always_ff @(posedge clk) begin
      if (rst) begin
        err_r <= CONST_LO;
      end else if (|y_q) begin
        err_r <= CONST_HI;
      end
    end

    assign err = err_r;
  end else begin : g_tie
    // clk/rst have no load in this configuration.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign y_q = {WIDTH{CONST_LO}};
    assign err = CONST_LO;
  end

endmodule

// File: tb/tb_const_low_src.sv
module tb_const_low_src;

  localparam int unsigned W    = 8;
  localparam int unsigned NCYC = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  // Left undriven on purpose: the floating instance must still output zeros.
  logic flt_clk;
  logic flt_rst;

  logic [W-1:0] y_a, yq_a, y_b, yq_b, y_f, yq_f;
  logic         err_a, err_b, err_f;

  const_low_src #(.WIDTH(W), .REG_COPY(1'b1)) dut_a (
    .clk (clk), .rst (rst), .y (y_a), .y_q (yq_a), .err (err_a)
  );

  const_low_src #(.WIDTH(W), .REG_COPY(1'b0)) dut_b (
    .clk (clk), .rst (rst), .y (y_b), .y_q (yq_b), .err (err_b)
  );

  const_low_src #(.WIDTH(W), .REG_COPY(1'b1)) dut_f (
    .clk (flt_clk), .rst (flt_rst), .y (y_f), .y_q (yq_f), .err (err_f)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Floating-input instance: y must be 0 at fixed sample times.
  initial begin
    #1;
    check_eq("flt_y_t1", 64'(y_f), 64'h0);
    check_eq("flt_yq_t1", 64'(yq_f), 64'h0);
    check_eq("flt_err_t1", 64'(err_f), 64'h0);
    #9;
    check_eq("flt_y_t10", 64'(y_f), 64'h0);
    #20;
    check_eq("flt_y_t30", 64'(y_f), 64'h0);
    #30;
    check_eq("flt_y_t60", 64'(y_f), 64'h0);
  end

  bit   rst_v [NCYC+1];
  bit   frc_v [NCYC];
  logic err_m;

  initial begin
    // Reset plan: two edges at start, a pulse at cycle 20, sparse random pulses later.
    for (int i = 0; i <= NCYC; i++) begin
      rst_v[i] = (i < 2) || (i == 20) || (i > 25 && $urandom_range(0, 15) == 0);
    end
    // Guaranteed override at cycle 40, held clear of reset until a pulse at 45.
    for (int i = 40; i <= 44; i++) rst_v[i] = 1'b0;
    rst_v[45]   = 1'b1;
    rst_v[NCYC] = 1'b0;
    // Overrides only where reset is low on that edge and the following one.
    for (int i = 0; i < NCYC; i++) begin
      frc_v[i] = (i > 30) && (i < NCYC - 1) && !rst_v[i] && !rst_v[i+1]
                 && ($urandom_range(0, 19) == 0);
    end
    frc_v[40] = 1'b1;

    err_m = 1'b0;

    // Registered copies come up at 0 before any reset edge.
    #1;
    check_eq("init_y", 64'(y_a), 64'h0);
    check_eq("init_yq", 64'(yq_a), 64'h0);
    check_eq("init_err", 64'(err_a), 64'h0);

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      if (i > 0 && frc_v[i-1]) release dut_a.y_q;
      rst = rst_v[i];
      if (frc_v[i]) force dut_a.y_q = 8'h01;
      @(posedge clk);
      // Reference: err is a sticky "copy was non-zero" flag, reset wins.
      if (rst_v[i]) err_m = 1'b0;
      else if (frc_v[i]) err_m = 1'b1;
      #1;
      check_eq("y_a", 64'(y_a), 64'h0);
      if (!frc_v[i]) check_eq("yq_a", 64'(yq_a), 64'h0);
      check_eq("err_a", 64'(err_a), 64'(err_m));
      check_eq("y_b", 64'(y_b), 64'h0);
      check_eq("yq_b", 64'(yq_b), 64'h0);
      check_eq("err_b", 64'(err_b), 64'h0);
    end
    if (frc_v[NCYC-1]) release dut_a.y_q;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
